afifo_w32_r64_d2048: RTL and testbench

//  Dual-clock FIFO with width conversion: 32-bit writes, 64-bit reads, 2048x32 (= 1024x64) storage.

---
 rtl/afifo_w32_r64_d2048_if.sv | 32 +++
 rtl/afifo_w32_r64_d2048.sv | 163 ++++++++++++++++
 tb/tb_afifo_w32_r64_d2048.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_w32_r64_d2048_if.sv
// Stream bundle for the 32-to-64 bit dual-clock FIFO.
// master drives write/read requests, slave is the FIFO itself.
`timescale 1ns/1ps
interface afifo_w32_r64_d2048_if #(
  parameter int WDW = 32,
  parameter int RDW = 64,
  parameter int WLW = 12,
  parameter int RLW = 11
);
  logic [WDW-1:0] wr_data;
  logic           wr_en;
  logic           wr_full;
  logic [WLW-1:0] wr_water_level;
  logic           almost_full;
  logic           rd_en;
  logic [RDW-1:0] rd_data;
  logic           rd_empty;
  logic [RLW-1:0] rd_water_level;
  logic           almost_empty;

  modport master (
    output wr_data, wr_en, rd_en,
    input  wr_full, wr_water_level, almost_full,
    input  rd_data, rd_empty, rd_water_level, almost_empty
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output wr_full, wr_water_level, almost_full,
    output rd_data, rd_empty, rd_water_level, almost_empty
  );
endinterface

// File: rtl/afifo_w32_r64_d2048.sv
// Dual-clock FIFO, 2048x32 in / 1024x64 out.
// Gray pointers cross domains through 2-flop synchronisers.
`timescale 1ns/1ps
module afifo_w32_r64_d2048 #(
  parameter int WR_DEPTH_WIDTH   = 11,
  parameter int WR_DATA_WIDTH    = 32,
  parameter int RD_DEPTH_WIDTH   = 10,
  parameter int RD_DATA_WIDTH    = 64,
  parameter int ALMOST_FULL_NUM  = 2047,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input logic clk,
  input logic rd_clk,
  input logic tb_rst,
  afifo_w32_r64_d2048_if.slave fifo_if
);
  localparam int WAW = WR_DEPTH_WIDTH + 1;
  localparam int RAW = RD_DEPTH_WIDTH + 1;
  localparam int RDEP = 1 << RD_DEPTH_WIDTH;

  localparam logic [WAW-1:0] WFULL = WAW'(1 << WR_DEPTH_WIDTH);
  localparam logic [WAW-1:0] AFULL = WAW'(ALMOST_FULL_NUM);
  localparam logic [RAW-1:0] AEMPTY = RAW'(ALMOST_EMPTY_NUM);

  function automatic logic [RAW-1:0] b2g(
    input logic [RAW-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [RAW-1:0] g2b(
    input logic [RAW-1:0] g
  );
    logic [RAW-1:0] b;
    b[RAW-1] = g[RAW-1];
    for (int i = RAW - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // ---------------- reset release sync ----------------
  logic [1:0] wrs;
  logic [1:0] rrs;
  logic       wr_rst_n;
  logic       rd_rst_n;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) wrs <= 2'b00;
    else        wrs <= {wrs[0], 1'b1};
  end

  always_ff @(posedge rd_clk or posedge tb_rst) begin
    if (tb_rst) rrs <= 2'b00;
    else        rrs <= {rrs[0], 1'b1};
  end

  assign wr_rst_n = wrs[1];
  assign rd_rst_n = rrs[1];

  // ---------------- storage ----------------
  logic [WR_DATA_WIDTH-1:0] mem_lo [RDEP];
  logic [WR_DATA_WIDTH-1:0] mem_hi [RDEP];

  // ---------------- write domain ----------------
  logic [WAW-1:0] wptr;
  logic [WAW-1:0] wptr_nxt;
  logic [WAW-1:0] wlvl_nxt;
  logic [RAW-1:0] wgray;
  logic [RAW-1:0] rg_w1;
  logic [RAW-1:0] rg_w2;
  logic [RAW-1:0] rbin_s;
  logic           wr_full;
  logic           wr_fire;
  logic [WAW-1:0] wr_lvl;
  logic           almost_full;

  assign wr_fire  = fifo_if.wr_en & ~wr_full;
  assign wptr_nxt = wptr + WAW'(wr_fire);
  assign rbin_s   = g2b(rg_w2);
  assign wlvl_nxt = wptr_nxt - {rbin_s, 1'b0};

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wptr[0])
        mem_hi[wptr[WR_DEPTH_WIDTH-1:1]] <= fifo_if.wr_data;
      else
        mem_lo[wptr[WR_DEPTH_WIDTH-1:1]] <= fifo_if.wr_data;
    end
  end

  // Only whole read words matter to the reader, so the
  // write pointer crosses as Gray of wptr>>1.
  always_ff @(posedge clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wptr        <= '0;
      wgray       <= '0;
      rg_w1       <= '0;
      rg_w2       <= '0;
      wr_full     <= 1'b0;
      wr_lvl      <= '0;
      almost_full <= 1'b0;
    end else begin
      wptr        <= wptr_nxt;
      wgray       <= b2g(wptr_nxt[WAW-1:1]);
      rg_w1       <= rgray;
      rg_w2       <= rg_w1;
      wr_full     <= wlvl_nxt == WFULL;
      wr_lvl      <= wlvl_nxt;
      almost_full <= wlvl_nxt >= AFULL;
    end
  end

  // ---------------- read domain ----------------
  logic [RAW-1:0]           rptr;
  logic [RAW-1:0]           rptr_nxt;
  logic [RAW-1:0]           rlvl_nxt;
  logic [RAW-1:0]           rgray;
  logic [RAW-1:0]           wg_r1;
  logic [RAW-1:0]           wg_r2;
  logic [RAW-1:0]           wbin_s;
  logic                     rd_empty;
  logic                     rd_fire;
  logic [RAW-1:0]           rd_lvl;
  logic                     almost_empty;
  logic [RD_DATA_WIDTH-1:0] rd_q;

  assign rd_fire  = fifo_if.rd_en & ~rd_empty;
  assign rptr_nxt = rptr + RAW'(rd_fire);
  assign wbin_s   = g2b(wg_r2);
  assign rlvl_nxt = wbin_s - rptr_nxt;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rptr         <= '0;
      rgray        <= '0;
      wg_r1        <= '0;
      wg_r2        <= '0;
      rd_empty     <= 1'b1;
      rd_lvl       <= '0;
      almost_empty <= 1'b1;
      rd_q         <= '0;
    end else begin
      rptr         <= rptr_nxt;
      rgray        <= b2g(rptr_nxt);
      wg_r1        <= wgray;
      wg_r2        <= wg_r1;
      rd_empty     <= wbin_s == rptr_nxt;
      rd_lvl       <= rlvl_nxt;
      almost_empty <= rlvl_nxt <= AEMPTY;
      if (rd_fire)
        rd_q <= {mem_hi[rptr[RD_DEPTH_WIDTH-1:0]],
                 mem_lo[rptr[RD_DEPTH_WIDTH-1:0]]};
    end
  end

  assign fifo_if.wr_full        = wr_full;
  assign fifo_if.wr_water_level = wr_lvl;
  assign fifo_if.almost_full    = almost_full;
  assign fifo_if.rd_data        = rd_q;
  assign fifo_if.rd_empty       = rd_empty;
  assign fifo_if.rd_water_level = rd_lvl;
  assign fifo_if.almost_empty   = almost_empty;
endmodule

// File: tb/tb_afifo_w32_r64_d2048.sv
// Scoreboard bench for the 32-to-64 dual-clock FIFO.
// Written words are paired into 64-bit expectations and popped on reads.
`timescale 1ns/1ps
module tb_afifo_w32_r64_d2048;
  logic clk = 1'b0;
  logic rclk_a = 1'b0;
  logic same_clk = 1'b1;
  logic rd_clk;
  logic tb_rst;

  always #5 clk = ~clk;
  always #3.5 rclk_a = ~rclk_a;
  assign rd_clk = same_clk ? clk : rclk_a;

  afifo_w32_r64_d2048_if fif ();

  afifo_w32_r64_d2048 dut (
    .clk     (clk),
    .rd_clk  (rd_clk),
    .tb_rst  (tb_rst),
    .fifo_if (fif.slave)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] sb [$];
  bit          have_lo = 0;
  logic [31:0] lo_q = '0;
  logic [63:0] last_rd = '0;
  bit          wdone = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    if (have_lo) begin
      sb.push_back({d, lo_q});
      have_lo = 0;
    end else begin
      lo_q = d;
      have_lo = 1;
    end
  endtask

  task automatic pop_chk();
    logic [63:0] e;
    if (sb.size() == 0) begin
      chk("underflow", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("rdata", fif.rd_data, e);
      last_rd = e;
    end
  endtask

  task automatic wr_word(input logic [31:0] d,
                         output bit acc);
    bit wf;
    @(negedge clk);
    wf = fif.wr_full;
    fif.wr_en = 1'b1;
    fif.wr_data = d;
    @(posedge clk);
    #1;
    fif.wr_en = 1'b0;
    acc = !wf;
    if (acc) push_word(d);
  endtask

  task automatic rd_word(output bit acc);
    bit re;
    @(negedge rd_clk);
    re = fif.rd_empty;
    fif.rd_en = 1'b1;
    @(posedge rd_clk);
    #1;
    fif.rd_en = 1'b0;
    acc = !re;
    if (acc) pop_chk();
    else chk("rd_hold", fif.rd_data, last_rd);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int waited;
    tb_rst = 1'b1;
    fif.wr_en = 1'b0;
    fif.rd_en = 1'b0;
    fif.wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tb_rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_empty", 64'(fif.rd_empty), 64'd1);
    chk("rst_aempty", 64'(fif.almost_empty), 64'd1);
    chk("rst_full", 64'(fif.wr_full), 64'd0);
    chk("rst_afull", 64'(fif.almost_full), 64'd0);
    chk("rst_wlvl", 64'(fif.wr_water_level), 64'd0);
    chk("rst_rlvl", 64'(fif.rd_water_level), 64'd0);
    chk("rst_rdata", fif.rd_data, 64'd0);

    for (int i = 0; i < 2049; i++) begin
      wr_word(32'hFFFF_FFFF - 32'(i), acc);
      if (i == 2045)
        chk("afull_2046", 64'(fif.almost_full), 64'd0);
      if (i == 2046) begin
        chk("afull_2047", 64'(fif.almost_full), 64'd1);
        chk("full_2047", 64'(fif.wr_full), 64'd0);
      end
      if (i == 2047) begin
        chk("full_2048", 64'(fif.wr_full), 64'd1);
        chk("wlvl_2048", 64'(fif.wr_water_level), 64'd2048);
      end
      if (i == 2048) begin
        chk("drop_2049", 64'(acc), 64'd0);
        chk("wlvl_hold", 64'(fif.wr_water_level), 64'd2048);
      end
    end
    repeat (5) @(posedge rd_clk);
    #1;
    chk("rlvl_full", 64'(fif.rd_water_level), 64'd1024);

    for (int j = 0; j < 1025; j++) begin
      rd_word(acc);
      if (j == 0)
        chk("rd_first", fif.rd_data, 64'hFFFFFFFE_FFFFFFFF);
      if (j == 1)
        chk("rd_second", fif.rd_data, 64'hFFFFFFFC_FFFFFFFD);
      if (j == 1023) begin
        chk("rd_last", fif.rd_data, 64'hFFFFF800_FFFFF801);
        chk("empty_last", 64'(fif.rd_empty), 64'd1);
      end
      if (j == 1024) begin
        chk("rd_drop", 64'(acc), 64'd0);
        chk("rd_hold_last", fif.rd_data, 64'hFFFFF800_FFFFF801);
      end
    end

    wr_word(32'h1111_0000, acc);
    repeat (6) @(posedge rd_clk);
    #1;
    chk("odd_empty", 64'(fif.rd_empty), 64'd1);
    chk("odd_rlvl", 64'(fif.rd_water_level), 64'd0);
    wr_word(32'h1111_0001, acc);
    waited = 0;
    while (fif.rd_empty && waited < 4) begin
      @(posedge rd_clk);
      #1;
      waited++;
    end
    chk("empty_lat", 64'(fif.rd_empty), 64'd0);
    chk("rlvl_1", 64'(fif.rd_water_level), 64'd1);
    chk("aempty_1", 64'(fif.almost_empty), 64'd1);
    for (int p = 2; p <= 5; p++) begin
      wr_word(32'h1111_0000 + 32'(2 * p - 2), acc);
      wr_word(32'h1111_0000 + 32'(2 * p - 1), acc);
      repeat (5) @(posedge rd_clk);
      #1;
      chk("rlvl_p", 64'(fif.rd_water_level), 64'(p));
      chk("aempty_p", 64'(fif.almost_empty), 64'(p <= 4));
    end

    for (int i = 0; i < 90; i++)
      wr_word(32'h2222_0000 + 32'(i), acc);
    repeat (5) @(posedge clk);
    #1;
    chk("wlvl_100", 64'(fif.wr_water_level), 64'd100);
    @(negedge clk);
    tb_rst = 1'b1;
    #1;
    chk("mrst_empty", 64'(fif.rd_empty), 64'd1);
    chk("mrst_rlvl", 64'(fif.rd_water_level), 64'd0);
    chk("mrst_wlvl", 64'(fif.wr_water_level), 64'd0);
    chk("mrst_rdata", fif.rd_data, 64'd0);
    sb.delete();
    have_lo = 0;
    last_rd = '0;
    same_clk = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    tb_rst = 1'b0;
    repeat (8) @(posedge rd_clk);
    #1;
    chk("post_empty", 64'(fif.rd_empty), 64'd1);

    fork
      begin : writer
        int nw;
        bit en;
        bit wf;
        nw = 0;
        for (int c = 0; c < 6000 && nw < 1000; c++) begin
          @(negedge clk);
          en = 1'($urandom_range(0, 1));
          wf = fif.wr_full;
          fif.wr_en = en;
          fif.wr_data = 32'hA500_0000 + 32'(nw);
          @(posedge clk);
          #1;
          if (en && !wf) begin
            push_word(32'hA500_0000 + 32'(nw));
            nw++;
          end
        end
        fif.wr_en = 1'b0;
        chk("wr_budget", 64'(nw), 64'd1000);
        wdone = 1;
      end
      begin : reader
        bit en;
        bit re;
        for (int c = 0; c < 12000; c++) begin
          if (wdone && sb.size() == 0) break;
          @(negedge rd_clk);
          en = 1'($urandom_range(0, 1));
          re = fif.rd_empty;
          fif.rd_en = en;
          @(posedge rd_clk);
          #1;
          if (en && !re) pop_chk();
        end
        fif.rd_en = 1'b0;
      end
    join

    chk("drain", 64'(sb.size()), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("end_empty", 64'(fif.rd_empty), 64'd1);
    chk("end_rlvl", 64'(fif.rd_water_level), 64'd0);
    chk("end_wlvl", 64'(fif.wr_water_level), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
